// File: rtl/lut_mod_reduce_if.sv
// lut_mod_reduce_if: handshake bundle for the serial modular reducer.
//   in_valid / in_ready / x_in    : operand acceptance (valid/ready)
//   out_valid / out_ready / y_out : result delivery (valid/ready)
// The master modport is the environment side (multiplier upstream and
// consumer downstream). The slave modport is the reducer itself.
interface lut_mod_reduce_if #(
  parameter int Q_W  = 49,
  parameter int IN_W = 98
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] x_in;
  logic            out_valid;
  logic            out_ready;
  logic [Q_W-1:0]  y_out;

  modport master (
    output in_valid, x_in, out_ready,
    input  in_ready, out_valid, y_out
  );

  modport slave (
    input  in_valid, x_in, out_ready,
    output in_ready, out_valid, y_out
  );
endinterface

// File: rtl/lut_mod_reduce.sv
// lut_mod_reduce: serial reducer computing x_in mod Q by Horner accumulation
// over 5-bit digits, most significant digit first. Each step forms
// t = acc*32 + d. The top 5 bits of t address a registered residue LUT that
// holds (c * 2^Q_W) mod Q. The LUT word is added to the low Q_W bits of t and
// the sum is brought back below Q with at most two conditional subtractions.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : lut_mod_reduce_if.slave (in_valid/in_ready/x_in,
//               out_valid/out_ready/y_out)
//   lut_addr  : registered 5-bit address to the residue LUT
//   lut_data  : LUT output, valid one cycle after lut_addr is sampled
//   op_cnt    : completed-operation counter, only when MODRED_CNT_EN is defined
//
// Optional feature macro: MODRED_CNT_EN (adds the op_cnt register and port).
module lut_mod_reduce #(
  parameter int             Q_W  = 49,
  parameter int             IN_W = 98,
  parameter logic [Q_W-1:0] Q    = 49'd549824583172097
) (
  input  logic             clk,
  input  logic             rst,
  lut_mod_reduce_if.slave  bus,
  output logic [4:0]       lut_addr,
  input  logic [Q_W-1:0]   lut_data
`ifdef MODRED_CNT_EN
  ,
  output logic [31:0]      op_cnt
`endif
);

  localparam int ND = (IN_W + 4) / 5;
  localparam int XW = ND * 5;
  localparam int KW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, ACC, DONE} state_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   x_ext;
  logic [XW-1:0]   x_r;      // remaining digits; the next one is always on top
  logic [Q_W-1:0]  low;      // t[Q_W-1:0] of the step in flight
  logic [Q_W-1:0]  acc;
  logic [Q_W-1:0]  acc_red;
  logic [KW-1:0]   k;
  logic            out_valid_r;
  logic [Q_W-1:0]  y_out_r;

  // Sum is below 2^Q_W + Q, which is below 3Q, so two subtractions suffice.
  function automatic logic [Q_W-1:0] mod_reduce3(input logic [Q_W:0] s);
    logic [Q_W:0] r;
    r = s;
    if (r >= {1'b0, Q}) r = r - {1'b0, Q};
    if (r >= {1'b0, Q}) r = r - {1'b0, Q};
    return r[Q_W-1:0];
  endfunction

  assign x_ext   = XW'(bus.x_in);
  assign acc_red = mod_reduce3({1'b0, low} + {1'b0, lut_data});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid)  state_nxt = ADDR;
      ADDR:                    state_nxt = ACC;
      ACC:  state_nxt = (k == '0) ? DONE : ADDR;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready = (state == IDLE);
  end

  // The address for a step is registered on the edge that enters ADDR, so it
  // is already stable when the LUT samples it on the ADDR->ACC edge. For the
  // first digit acc is zero, so the address is zero and low is the digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      k           <= '0;
      lut_addr    <= 5'd0;
      out_valid_r <= 1'b0;
      y_out_r     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          acc      <= '0;
          k        <= KW'(ND - 1);
          lut_addr <= 5'd0;
        end
        ACC: begin
          acc <= acc_red;
          if (k == '0) begin
            y_out_r     <= acc_red;
            out_valid_r <= 1'b1;
          end else begin
            k        <= k - 1'b1;
            lut_addr <= acc_red[Q_W-1 -: 5];
          end
        end
        DONE: if (bus.out_ready) out_valid_r <= 1'b0;
        default: ;
      endcase
    end
  end

  // Operand shift register and low half of t; meaningless outside an
  // operation, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      x_r <= x_ext << 5;
      low <= {{(Q_W-5){1'b0}}, x_ext[XW-1 -: 5]};
    end else if (state == ACC && k != '0) begin
      x_r <= x_r << 5;
      low <= {acc_red[Q_W-6:0], x_r[XW-1 -: 5]};
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.y_out     = y_out_r;

`ifdef MODRED_CNT_EN
  logic [31:0] op_cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             op_cnt_r <= '0;
    else if (state == DONE && bus.out_ready) op_cnt_r <= op_cnt_r + 32'd1;
  end

  assign op_cnt = op_cnt_r;
`endif

endmodule

// File: doc/lut_mod_reduce.md
# lut_mod_reduce

Serial modular reducer for the Raccoon arithmetic datapath. It takes a double-width product (up to 98 bits, e.g. from a 49×49 multiplier) and returns the product mod Q. It works by Horner accumulation over 5-bit digits. It drives the 5-bit address port of a 32-entry registered residue LUT instance of the LUT5 family and consumes that LUT's 49-bit output one cycle later. The LUT instance holds entry c = (c·R) mod Q, where R = 2^49 mod Q = 13125370249215. The block sits directly upstream of that LUT and downstream of the multiplier.

## Interface
- Q_W, 49, modulus / residue width
- IN_W, 98, input width; zero-extended internally to ND·5 bits, ND = ceil(IN_W/5) = 20
- Q, 49'd549824583172097, modulus (Raccoon q)
- clk  input  1  sole clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  x_in is valid
- in_ready  output  1  block can accept; high only in IDLE
- x_in  input  IN_W  value to reduce
- lut_addr  output  5  address to the residue LUT
- lut_data  input  Q_W  LUT Dout; valid the cycle after lut_addr is sampled
- out_valid  output  1  y_out holds a result
- out_ready  input  1  downstream accepts y_out
- y_out  output  Q_W  x_in mod Q, always < Q
- op_cnt  output  32  completed-operation count; present only with MODRED_CNT_EN

## Operation
- FSM states: IDLE, ADDR, ACC, DONE.
- Reset values: state=IDLE, acc=0, digit index=0, lut_addr=0, out_valid=0, y_out=0, op_cnt=0. in_ready=1 once reset deasserts.
- IDLE: in_ready=1.
  - On in_valid, capture x_in zero-extended to 100 bits, set acc=0, set digit index k=ND-1, go to ADDR.
- ADDR: form t = acc·32 + d_k, where d_k = x[5k+4:5k].
  - t < 2^54 because acc < Q.
  - lut_addr = t[53:49].
  - Register low = t[48:0]. Go to ACC.
- ACC: sum = low + lut_data (50 bits, < 2^49+Q < 3Q).
  - Reduce with up to two conditional subtractions of Q, giving acc < Q.
  - If k=0: y_out=acc, out_valid=1, go to DONE.
  - Otherwise decrement k and go to ADDR.
- DONE: hold y_out and out_valid until out_ready=1. Then drop out_valid and go to IDLE. y_out retains its last value.
- lut_addr is registered. It changes only on the ADDR entry edge and is stable through the LUT sampling edge.
- in_valid is ignored outside IDLE. x_in is not re-sampled mid-operation.
- rst at any point returns all registers to reset values within the same cycle (async). Any in-flight result is discarded; no out_valid pulse.

## Timing
- Acceptance edge E0 (in_valid and in_ready both high) starts an operation.
- Each digit costs 2 cycles (ADDR, ACC), because the next address depends on the updated acc.
- out_valid rises at edge E0+2·ND = E0+40 for the default parameters.
- Minimum initiation interval: 42 cycles.
  - 40 compute cycles, plus ≥1 DONE cycle, plus 1 IDLE cycle.
  - With out_ready held high, the next in_ready is seen at E0+42.
- LUT latency assumption: exactly 1 cycle (registered Dout). lut_data is sampled only in ACC.

## Configuration
- MODRED_CNT_EN defined:
  - Adds a 32-bit op_cnt register and port.
  - op_cnt increments on each DONE→IDLE handoff (out_valid and out_ready both high).
  - Wraps at 2^32−1 → 0. Cleared by rst.
- Not defined:
  - No op_cnt port or register.
  - All other behaviour and timing are identical.

## Test plan
- x_in=0 → y_out=0; out_valid at E0+40; lut_addr=0 throughout.
- x_in=Q → y_out=0. x_in=Q−1 → y_out=549824583172096. x_in=2^49 → y_out=13125370249215.
- x_in=(Q−1)^2 → y_out=1. x_in=2^98−1 → result matches the reference model (2^98−1) mod Q.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid: y_out stable, in_ready=0, a new in_valid is ignored.
  - Release out_ready: next acceptance happens one cycle later.
- Reset mid-op: assert rst at E0+17.
  - All outputs return to reset values immediately; no out_valid follows.
  - A new x_in=5 after reset → y_out=5.
- With MODRED_CNT_EN: 3 back-to-back ops → op_cnt=3. Preload near wrap, then 2 ops → op_cnt=0. Random 1000-vector regression against the golden model in both build configurations.
